// File: rtl/shift_add_multiplier.sv
// Sequential shift-and-add multiplier with a valid/ready handshake on both
// sides. One operand pair is accepted in IDLE. BUSY then runs WIDTH add/shift
// iterations on unsigned magnitudes. The sign is reapplied when the result
// loads into product, and DONE holds product until the consumer takes it.
module shift_add_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [2*WIDTH-1:0] mcand;    // multiplicand magnitude, shifts left
  logic [WIDTH:0]     mplier;   // multiplier magnitude, shifts right
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      iter;
  logic               negate;

  logic [WIDTH:0]     a_ext, b_ext, a_mag, b_mag;
  logic [2*WIDTH-1:0] acc_sum;
  logic               accept, last_iter;

  // Handshake flags decode directly from the registered state.
  assign in_ready  = (state == IDLE);
  assign busy      = (state == BUSY);
  assign out_valid = (state == DONE);

  assign accept    = in_ready && in_valid;
  assign last_iter = (iter == LAST_ITER);

  // Operand magnitudes and the partial sum for the current iteration.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    a_ext   = {signed_mode & a[WIDTH-1], a};
    b_ext   = {signed_mode & b[WIDTH-1], b};
    a_mag   = a_ext[WIDTH] ? -a_ext : a_ext;
    b_mag   = b_ext[WIDTH] ? -b_ext : b_ext;
    acc_sum = acc + (mplier[0] ? mcand : '0);
  end

  // State register. Reset wins over every handshake event.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)  state_next = BUSY;
      BUSY:    if (last_iter) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture on acceptance, iterate in BUSY, load product on the last iteration.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: all datapath registers clear on reset so an aborted run leaves nothing visible.
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      iter    <= '0;
      negate  <= 1'b0;
      product <= '0;
    end else begin
      if (accept) begin
        mcand  <= {{(WIDTH-1){1'b0}}, a_mag};
        mplier <= b_mag;
        acc    <= '0;
        iter   <= '0;
        negate <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
      end else if (state == BUSY) begin
        acc    <= acc_sum;
        mplier <= mplier >> 1;
        mcand  <= mcand << 1;
        iter   <= iter + CW'(1);
        if (last_iter) product <= negate ? -acc_sum : acc_sum;
      end
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier (WIDTH=4). Directed cases cover
// the corner values. An exhaustive sweep of both modes follows, with random
// consumer stalls and random input churn while the block is busy. Expected
// products come from plain integer multiplication.
module tb_shift_add_multiplier;

  localparam int WIDTH = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               signed_mode;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] product;
  logic               busy;

  int n_cmp = 0;
  int n_bad = 0;

  shift_add_multiplier #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .signed_mode (signed_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .product     (product),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: interpret operands per mode, multiply as integers, keep 2*WIDTH bits.
  function automatic logic [2*WIDTH-1:0] ref_mul(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y,
                                                 input logic s);
    int xi, yi;
    xi = int'(x);
    yi = int'(y);
    if (s && x[WIDTH-1]) xi -= (1 << WIDTH);
    if (s && y[WIDTH-1]) yi -= (1 << WIDTH);
    return (2*WIDTH)'(xi * yi);
  endfunction

  // One full transaction, starting and ending #1 after a rising edge in IDLE.
  // The acceptance edge counts as edge 1, so out_valid must appear at edge WIDTH+1.
  task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                        input logic ts, input int stall, input bit churn,
                        output logic [2*WIDTH-1:0] got);
    logic [2*WIDTH-1:0] exp;
    int edges;
    exp = ref_mul(ta, tb_v, ts);
    check("in_ready_before_accept", in_ready, 1);
    a = ta; b = tb_v; signed_mode = ts; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    edges = 1;
    check("busy_after_accept", busy, 1);
    while (!out_valid && edges < 40) begin
      if (churn) begin
        a = WIDTH'($urandom); b = WIDTH'($urandom);
        signed_mode = 1'($urandom); in_valid = 1'($urandom);
      end
      @(posedge clk); #1;
      edges++;
    end
    in_valid = 1'b0;
    check("latency_edges", edges, WIDTH + 1);
    check("product", product, exp);
    got = product;
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      check("stall_out_valid", out_valid, 1);
      check("stall_product", product, exp);
      check("stall_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("idle_in_ready", in_ready, 1);
    check("idle_out_valid", out_valid, 0);
    check("idle_product_held", product, exp);
  endtask

  initial begin
    logic [2*WIDTH-1:0] got;
    bit seen_valid;

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; signed_mode = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_product", product, 0);

    // Reset beats acceptance.
    in_valid = 1'b1; a = 4'd3; b = 4'd3;
    @(posedge clk); #1;
    in_valid = 1'b0; rst = 1'b0;
    check("rst_prio_busy", busy, 0);
    check("rst_prio_in_ready", in_ready, 1);

    // Directed cases.
    run_op(4'd15, 4'd15, 1'b0, 0, 1'b0, got);
    check("u_15x15", got, 8'hE1);
    run_op(4'b1000, 4'd7, 1'b1, 0, 1'b0, got);
    check("s_m8x7", got, 8'hC8);
    run_op(4'b1000, 4'b1000, 1'b1, 0, 1'b0, got);
    check("s_m8xm8", got, 8'h40);
    run_op(4'b1111, 4'd1, 1'b1, 0, 1'b0, got);
    check("s_m1x1", got, 8'hFF);
    run_op(4'd0, 4'b1011, 1'b1, 0, 1'b0, got);
    check("s_0xm5", got, 8'h00);
    run_op(4'd3, 4'd5, 1'b0, 10, 1'b0, got);
    check("bp_3x5", got, 8'h0F);
    run_op(4'd2, 4'd3, 1'b0, 1, 1'b1, got);
    check("churn_2x3", got, 8'h06);
    @(posedge clk); #1;
    check("no_second_accept", in_ready, 1);

    // Reset in the middle of 9 x 9: nothing may surface, then a clean 4 x 4.
    a = 4'd9; b = 4'd9; signed_mode = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_in_ready", in_ready, 1);
    check("abort_busy", busy, 0);
    check("abort_product", product, 0);
    seen_valid = 1'b0;
    for (int i = 0; i < WIDTH + 3; i++) begin
      seen_valid |= out_valid;
      @(posedge clk); #1;
    end
    check("abort_no_out_valid", seen_valid, 0);
    run_op(4'd4, 4'd4, 1'b0, 0, 1'b0, got);
    check("after_abort_4x4", got, 8'h10);

    // Exhaustive sweep, both modes, random stalls and input churn.
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < (1 << WIDTH); i++)
        for (int j = 0; j < (1 << WIDTH); j++)
          run_op(WIDTH'(i), WIDTH'(j), 1'(m), int'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), got);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
